// File: rtl/dependence_pkg.sv
// Shared types and constants for the dependence-logic stimulus driver.
//   drv_state_e        : driver FSM states
//   MODE_BAC / MODE_AB : function select, expected = b&(a|c) or a&b
//   LAST_VEC_*         : final vector index for each mode
//   gold_bac / gold_ab : golden functions used by the checker
package dependence_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } drv_state_e;

    localparam logic MODE_BAC = 1'b0;
    localparam logic MODE_AB  = 1'b1;

    localparam logic [2:0] LAST_VEC_BAC = 3'd7;
    localparam logic [2:0] LAST_VEC_AB  = 3'd3;

    function automatic logic gold_bac(input logic a, input logic b, input logic c);
        return b & (a | c);
    endfunction

    function automatic logic gold_ab(input logic a, input logic b);
        return a & b;
    endfunction

endpackage

// File: rtl/dependence_golden.sv
// Combinational golden model: the bit a correct dependence block must
// produce for the given inputs in the selected mode.
//   mode     in : MODE_BAC or MODE_AB
//   a, b, c  in : the stimulus bits currently driven to the DUT
//   expected out: golden output bit
module dependence_golden
    import dependence_pkg::*;
(
    input  logic mode,
    input  logic a,
    input  logic b,
    input  logic c,
    output logic expected
);

    always_comb begin
        expected = (mode == MODE_AB) ? gold_ab(a, b) : gold_bac(a, b, c);
    end

endmodule

// File: rtl/dependence_driver.sv
// Exhaustive stimulus driver and checker for a combinational dependence
// block. Sweeps every input vector, waits SETTLE cycles, samples the DUT
// output and counts mismatches against the golden function.
//   clk, rst_n       : clock, synchronous active-low reset
//   start, mode      : begin a sweep / function select (latched at start)
//   drv_a/b/c        : registered stimulus to the DUT
//   dut_q            : DUT output
//   busy, done       : sweep in progress / one-cycle end-of-sweep pulse
//   pass, err_cnt    : sweep result, saturating mismatch count
//   first_err_valid/vec : first failing vector of the sweep
//   dbg_state        : current FSM state for observation
//
// Handshake: start acts as a request that is accepted only on an edge where
// busy is low (IDLE); a start seen while busy is dropped, never queued.
module dependence_driver
    import dependence_pkg::*;
#(
    parameter int SETTLE = 1,
    parameter int ERR_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    output logic             drv_a,
    output logic             drv_b,
    output logic             drv_c,
    input  logic             dut_q,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic             first_err_valid,
    output logic [2:0]       first_err_vec,
    output drv_state_e       dbg_state
);

    localparam logic [3:0]       WAIT_LAST = 4'(SETTLE - 1);
    localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

    drv_state_e       state;
    drv_state_e       state_nxt;
    logic             mode_q;
    logic [2:0]       vec;
    logic [3:0]       wait_cnt;
    logic             expected;
    logic             mismatch;
    logic [2:0]       last_vec;
    logic [ERR_W-1:0] err_nxt;

    // Golden value is taken from the bits actually on the DUT pins, so the
    // checker and the stimulus can never disagree about the vector.
    dependence_golden u_golden (
        .mode     (mode_q),
        .a        (drv_a),
        .b        (drv_b),
        .c        (drv_c),
        .expected (expected)
    );

    assign mismatch  = (dut_q != expected);
    assign last_vec  = (mode_q == MODE_AB) ? LAST_VEC_AB : LAST_VEC_BAC;
    assign err_nxt   = (mismatch && (err_cnt != ERR_MAX)) ? err_cnt + ERR_W'(1) : err_cnt;
    assign dbg_state = state;

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = LOAD;
            end
            LOAD:  state_nxt = WAIT;
            WAIT:  if (wait_cnt == WAIT_LAST) state_nxt = CHECK;
            CHECK: state_nxt = (vec == last_vec) ? DONE : LOAD;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            mode_q          <= MODE_BAC;
            vec             <= '0;
            wait_cnt        <= '0;
            drv_a           <= 1'b0;
            drv_b           <= 1'b0;
            drv_c           <= 1'b0;
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
            pass            <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    drv_a <= 1'b0;
                    drv_b <= 1'b0;
                    drv_c <= 1'b0;
                    if (start) begin
                        mode_q          <= mode;
                        vec             <= '0;
                        err_cnt         <= '0;
                        first_err_valid <= 1'b0;
                        first_err_vec   <= '0;
                        pass            <= 1'b0;
                    end
                end
                LOAD: begin
                    if (mode_q == MODE_AB) begin
                        drv_a <= vec[1];
                        drv_b <= vec[0];
                        drv_c <= 1'b0;
                    end else begin
                        drv_a <= vec[2];
                        drv_b <= vec[1];
                        drv_c <= vec[0];
                    end
                    wait_cnt <= '0;
                end
                WAIT: wait_cnt <= wait_cnt + 4'd1;
                CHECK: begin
                    err_cnt <= err_nxt;
                    if (mismatch && !first_err_valid) begin
                        first_err_valid <= 1'b1;
                        first_err_vec   <= vec;
                    end
                    // pass must already be valid while done is high, so it
                    // uses the count including this final comparison.
                    if (vec == last_vec) pass <= (err_nxt == '0);
                    else                 vec  <= vec + 3'd1;
                end
                DONE: begin
                    drv_a <= 1'b0;
                    drv_b <= 1'b0;
                    drv_c <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dependence_driver.sv
module tb_dependence_driver;
    import dependence_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start;
    logic       mode;
    logic [7:0] tt;   // behaviour of the block under test, indexed by {a,b,c}

    logic       a0, b0, c0, q0, busy0, done0, pass0, fval0;
    logic [3:0] err0;
    logic [2:0] fv0;
    drv_state_e st0;
    logic       a1, b1, c1, q1, busy1, done1, pass1, fval1;
    logic [1:0] err1;
    logic [2:0] fv1;
    drv_state_e st1;

    assign q0 = tt[{a0, b0, c0}];
    assign q1 = tt[{a1, b1, c1}];

    dependence_driver #(.SETTLE(1), .ERR_W(4)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .drv_a(a0), .drv_b(b0), .drv_c(c0), .dut_q(q0),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
        .first_err_valid(fval0), .first_err_vec(fv0), .dbg_state(st0)
    );

    dependence_driver #(.SETTLE(3), .ERR_W(2)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .drv_a(a1), .drv_b(b1), .drv_c(c1), .dut_q(q1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
        .first_err_valid(fval1), .first_err_vec(fv1), .dbg_state(st1)
    );

    logic       busy_v [2];
    logic       done_v [2];
    logic       pass_v [2];
    logic       fval_v [2];
    logic [2:0] drv_v  [2];
    logic [2:0] fv_v   [2];
    logic [3:0] err_v  [2];
    logic [2:0] st_v   [2];

    assign busy_v[0] = busy0;  assign busy_v[1] = busy1;
    assign done_v[0] = done0;  assign done_v[1] = done1;
    assign pass_v[0] = pass0;  assign pass_v[1] = pass1;
    assign fval_v[0] = fval0;  assign fval_v[1] = fval1;
    assign drv_v[0]  = {a0, b0, c0};
    assign drv_v[1]  = {a1, b1, c1};
    assign fv_v[0]   = fv0;    assign fv_v[1]   = fv1;
    assign err_v[0]  = err0;   assign err_v[1]  = {2'b00, err1};
    assign st_v[0]   = st0;    assign st_v[1]   = st1;

    // ---------------- reference model ----------------
    int         sv [2] = '{1, 3};
    int         wv [2] = '{4, 2};
    bit         act    [2];
    int         t      [2];
    int         sc     [2];
    bit         mode_l [2];
    logic [7:0] tt_l   [2];
    int         h_err  [2];
    int         h_fv   [2];
    bit         h_fval [2];
    bit         h_pass [2];
    int         done_cnt [2];
    int         done_cyc [2];
    int         cyc;
    bit         model_ok;
    int         checks;
    int         errors;

    function automatic int nvec(input bit m);
        return m ? 4 : 8;
    endfunction

    // {a,b,c} presented for vector k
    function automatic int vidx(input bit m, input int k);
        return m ? (k * 2) : k;
    endfunction

    function automatic bit gold(input bit m, input int k);
        bit a, b, c;
        if (m) begin
            a = k[1]; b = k[0];
            return a & b;
        end
        a = k[2]; b = k[1]; c = k[0];
        return b & (a | c);
    endfunction

    function automatic void calc(input int i, input int n_chk, output int raw,
                                 output bit fval, output int fv);
        raw = 0; fval = 0; fv = 0;
        for (int k = 0; k < n_chk; k++) begin
            if (tt_l[i][vidx(mode_l[i], k)] != gold(mode_l[i], k)) begin
                if (!fval) begin fval = 1; fv = k; end
                raw++;
            end
        end
    endfunction

    function automatic int sat(input int i, input int raw);
        int mx;
        mx = (1 << wv[i]) - 1;
        return (raw > mx) ? mx : raw;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act_v, exp_v, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            for (int i = 0; i < 2; i++) begin
                int raw, fvv;
                bit fl;
                if (!rst_n) begin
                    act[i] = 0; h_err[i] = 0; h_fv[i] = 0; h_fval[i] = 0; h_pass[i] = 0;
                    model_ok = 1;
                end else if (act[i]) begin
                    t[i]++;
                    if (t[i] > nvec(mode_l[i]) * (sv[i] + 2) + 1) begin
                        act[i] = 0;
                        calc(i, nvec(mode_l[i]), raw, fl, fvv);
                        h_err[i] = sat(i, raw); h_fval[i] = fl; h_fv[i] = fvv;
                        h_pass[i] = (raw == 0);
                    end
                end else if (start) begin
                    act[i] = 1; t[i] = 1; sc[i] = cyc; mode_l[i] = mode; tt_l[i] = tt;
                end
            end
            @(negedge clk);
            if (model_ok) begin
                for (int i = 0; i < 2; i++) begin
                    int nn, nck, k, ph, raw, fvv, e_err, e_fv;
                    bit fl, e_busy, e_done, e_pass, e_fval;
                    logic [2:0] e_drv, e_st;
                    if (act[i]) begin
                        nn  = nvec(mode_l[i]) * (sv[i] + 2);
                        nck = (t[i] - 1) / (sv[i] + 2);
                        if (nck > nvec(mode_l[i])) nck = nvec(mode_l[i]);
                        calc(i, nck, raw, fl, fvv);
                        e_busy = 1; e_done = (t[i] == nn + 1);
                        k  = (t[i] - 1) / (sv[i] + 2);
                        ph = (t[i] - 1) % (sv[i] + 2);
                        if (e_done) begin
                            e_drv = 3'(vidx(mode_l[i], nvec(mode_l[i]) - 1)); e_st = DONE;
                        end else if (ph == 0) begin
                            e_drv = (k == 0) ? 3'd0 : 3'(vidx(mode_l[i], k - 1)); e_st = LOAD;
                        end else begin
                            e_drv = 3'(vidx(mode_l[i], k));
                            e_st  = (ph == sv[i] + 1) ? CHECK : WAIT;
                        end
                        e_err = sat(i, raw); e_fval = fl; e_fv = fvv;
                        e_pass = e_done && (raw == 0);
                    end else begin
                        e_busy = 0; e_done = 0; e_drv = 3'd0; e_st = IDLE;
                        e_err = h_err[i]; e_fval = h_fval[i]; e_fv = h_fv[i]; e_pass = h_pass[i];
                    end
                    chk($sformatf("u%0d.busy", i),  busy_v[i], e_busy);
                    chk($sformatf("u%0d.done", i),  done_v[i], e_done);
                    chk($sformatf("u%0d.drv", i),   drv_v[i],  e_drv);
                    chk($sformatf("u%0d.state", i), st_v[i],   e_st);
                    chk($sformatf("u%0d.err", i),   err_v[i],  e_err);
                    chk($sformatf("u%0d.fval", i),  fval_v[i], e_fval);
                    chk($sformatf("u%0d.fvec", i),  fv_v[i],   e_fv);
                    chk($sformatf("u%0d.pass", i),  pass_v[i], e_pass);
                    if (done_v[i] === 1'b1) begin
                        done_cnt[i]++;
                        done_cyc[i] = cyc - sc[i] + 1;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy0 === 1'b1 || busy1 === 1'b1) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({nm, ".idle"}, {busy0, busy1}, 0);
    endtask

    task automatic sweep(input bit m, input logic [7:0] tbl, input int mid);
        wait_idle("pre");
        @(posedge clk); #2;
        tt = tbl; mode = m; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        mode  = 1'($urandom_range(0, 1));
        if (mid > 0) begin
            repeat (mid) @(posedge clk);
            #2 start = 1'b1;
            @(posedge clk); #2 start = 1'b0;
        end
        wait_idle("sweep");
    endtask

    initial begin
        int d0, d1;
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; tt = 8'h00;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("reset.busy0", busy0, 0);
        chk("reset.err0", err0, 0);
        chk("reset.pass1", pass1, 0);
        chk("reset.drv0", {a0, b0, c0}, 0);

        // mode 0, correct b&(a|c) block
        sweep(0, 8'hC8, 0);
        chk("bac_ok.done_cyc0", done_cyc[0], 25);
        chk("bac_ok.done_cyc1", done_cyc[1], 41);
        chk("bac_ok.err0", err0, 0);
        chk("bac_ok.pass0", pass0, 1);
        chk("bac_ok.fval0", fval0, 0);
        chk("bac_ok.pass1", pass1, 1);

        // mode 0 against an a&b block: single miss at vector 3
        sweep(0, 8'hC0, 0);
        chk("bac_vs_ab.err0", err0, 1);
        chk("bac_vs_ab.fvec0", fv0, 3);
        chk("bac_vs_ab.fval0", fval0, 1);
        chk("bac_vs_ab.pass0", pass0, 0);
        chk("bac_vs_ab.model", h_err[0], 1);

        // stuck-at-1: five misses, saturating at 3 on the 2-bit counter
        sweep(0, 8'hFF, 0);
        chk("stuck1.err1", err1, 3);
        chk("stuck1.fvec1", fv1, 0);
        chk("stuck1.pass1", pass1, 0);
        chk("stuck1.err0", err0, 5);
        chk("stuck1.model", h_err[1], 3);

        // mode 1, correct a&b block
        sweep(1, 8'hC0, 0);
        chk("ab_ok.done_cyc1", done_cyc[1], 21);
        chk("ab_ok.done_cyc0", done_cyc[0], 13);
        chk("ab_ok.pass1", pass1, 1);
        chk("ab_ok.pass0", pass0, 1);

        // start pulsed mid-sweep is ignored
        d0 = done_cnt[0]; d1 = done_cnt[1];
        sweep(0, 8'hC8, 5);
        chk("midstart.done_cnt0", done_cnt[0] - d0, 1);
        chk("midstart.done_cnt1", done_cnt[1] - d1, 1);

        // reset in cycle 10 of a sweep
        d0 = done_cnt[0]; d1 = done_cnt[1];
        wait_idle("rst_pre");
        @(posedge clk); #2;
        tt = 8'hFF; mode = 1'b0; start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("rst.pre_err0", err0, 3);
        chk("rst.pre_err1", err1, 1);
        rst_n = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst.busy", {busy0, busy1}, 0);
        chk("rst.drv", {a0, b0, c0, a1, b1, c1}, 0);
        chk("rst.err", {err0, err1}, 0);
        chk("rst.fval", {fval0, fval1}, 0);
        repeat (30) @(posedge clk);
        chk("rst.no_done0", done_cnt[0] - d0, 0);
        chk("rst.no_done1", done_cnt[1] - d1, 0);
        sweep(0, 8'hC8, 0);
        chk("rst.after_pass0", pass0, 1);
        chk("rst.after_done0", done_cnt[0] - d0, 1);

        // randomized blocks and modes
        for (int r = 0; r < 8; r++) begin
            logic [7:0] rt;
            bit         rm;
            int         rmid;
            rt   = 8'($urandom);
            rm   = 1'($urandom_range(0, 1));
            rmid = $urandom_range(0, 8);
            sweep(rm, rt, rmid);
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
